// File: rtl/dcache_port_arbiter.sv
// Shares the single L1 D-cache request port between loads and store-buffer drains.
// Loads win unless the store is urgent; an in-order tag FIFO routes read data back and drops flushed loads.
module dcache_port_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8,
  parameter int PLEN            = 32,
  parameter int XLEN            = 32,
  parameter int OP_W            = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ld_req_valid_i,
  output logic            ld_req_ready_o,
  input  logic [PLEN-1:0] ld_req_addr_i,
  input  logic [OP_W-1:0] ld_req_op_i,
  output logic            ld_resp_valid_o,
  output logic [XLEN-1:0] ld_resp_data_o,
  input  logic            sb_req_valid_i,
  output logic            sb_req_ready_o,
  input  logic [PLEN-1:0] sb_req_addr_i,
  input  logic [XLEN-1:0] sb_req_data_i,
  input  logic [OP_W-1:0] sb_req_op_i,
  input  logic            sb_pressure_i,
  output logic            dc_req_valid_o,
  input  logic            dc_req_ready_i,
  output logic            dc_req_we_o,
  output logic [PLEN-1:0] dc_req_addr_o,
  output logic [XLEN-1:0] dc_req_wdata_o,
  output logic [OP_W-1:0] dc_req_op_o,
  input  logic            dc_resp_valid_i,
  input  logic [XLEN-1:0] dc_resp_rdata_i,
  input  logic            flush_i,
  output logic            idle_o
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic vld;
    logic is_load;
    logic killed;
  } tag_t;

  tag_t [MAX_OUTSTANDING-1:0] r_tags;
  logic [PTR_W-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]           r_count;
  logic [ST_W-1:0]            r_starve;

  logic w_full, w_ld_cand, w_sb_cand, w_urgent, w_sb_win, w_ld_win, w_fire, w_pop;
  tag_t w_head;

  assign w_full    = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_ld_cand = ld_req_valid_i && !flush_i;
  assign w_sb_cand = sb_req_valid_i;
  assign w_urgent  = sb_pressure_i || (r_starve == ST_W'(STARVE_LIMIT));
  assign w_sb_win  = w_sb_cand && (w_urgent || !w_ld_cand);
  assign w_ld_win  = w_ld_cand && !w_sb_win;

  assign dc_req_valid_o = (w_ld_cand || w_sb_cand) && !w_full;
  assign w_fire         = dc_req_valid_o && dc_req_ready_i;
  assign ld_req_ready_o = w_ld_win && dc_req_ready_i && !w_full;
  assign sb_req_ready_o = w_sb_win && dc_req_ready_i && !w_full;

  always_comb begin
    dc_req_we_o    = 1'b0;
    dc_req_addr_o  = '0;
    dc_req_wdata_o = '0;
    dc_req_op_o    = '0;
    if (w_sb_win) begin
      dc_req_we_o    = 1'b1;
      dc_req_addr_o  = sb_req_addr_i;
      dc_req_wdata_o = sb_req_data_i;
      dc_req_op_o    = sb_req_op_i;
    end else if (w_ld_win) begin
      dc_req_addr_o  = ld_req_addr_i;
      dc_req_op_o    = ld_req_op_i;
    end
  end

  // A response with nothing outstanding is a protocol error and is ignored entirely.
  assign w_head          = r_tags[r_rd_ptr];
  assign w_pop           = dc_resp_valid_i && (r_count != '0);
  assign ld_resp_valid_o = w_pop && w_head.is_load && !w_head.killed && !flush_i;
  assign ld_resp_data_o  = ld_resp_valid_o ? dc_resp_rdata_i : '0;
  assign idle_o          = (r_count == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tags   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_fire, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (w_pop && PTR_W'(i) == r_rd_ptr) r_tags[i].vld <= 1'b0;
        if (w_fire && PTR_W'(i) == r_wr_ptr)
          r_tags[i] <= '{vld: 1'b1, is_load: w_ld_win, killed: 1'b0};
        else if (flush_i && r_tags[i].vld && r_tags[i].is_load)
          r_tags[i].killed <= 1'b1;
      end
      if (!sb_req_valid_i || (w_fire && w_sb_win)) r_starve <= '0;
      else if (r_starve != ST_W'(STARVE_LIMIT))   r_starve <= r_starve + 1'b1;
    end
  end

  always @(posedge clk_i)
    if (rst_ni)
      assert (!(dc_resp_valid_i && r_count == '0))
        else $warning("dcache_port_arbiter: D-cache response with no outstanding request");

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single L1 D-cache request port between the load unit (reads) and the store buffer drain (committed-store writes).
- Loads normally win.
- Stores are forced through when the store buffer reports pressure, or after a bounded starvation interval.
- Tracks in-flight requests in an in-order tag FIFO so that read data is routed back to the load unit, and loads killed by a flush are dropped.

Parameters:
- MAX_OUTSTANDING, 4, maximum requests accepted by D-cache but not yet responded to (power of two, ≥2)
- STARVE_LIMIT, 8, consecutive cycles a valid store may lose arbitration before it gets forced priority (≥1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- ld_req_valid_i  in  1  load request valid
- ld_req_ready_o  out  1  load request accepted this cycle
- ld_req_addr_i  in  Cfg.PLEN  load physical address
- ld_req_op_i  in  decode_pkg::lsu_op_e  load op
- ld_resp_valid_o  out  1  load data valid
- ld_resp_data_o  out  Cfg.XLEN  load data (raw D-cache read data)
- sb_req_valid_i  in  1  store-buffer head ready to write
- sb_req_ready_o  out  1  store accepted; the store buffer dequeues its head on this
- sb_req_addr_i  in  Cfg.PLEN  store address
- sb_req_data_i  in  Cfg.XLEN  store data
- sb_req_op_i  in  decode_pkg::lsu_op_e  store op
- sb_pressure_i  in  1  store buffer near full; store gets priority
- dc_req_valid_o  out  1  D-cache request valid
- dc_req_ready_i  in  1  D-cache accepts request
- dc_req_we_o  out  1  1 = write (store), 0 = read (load)
- dc_req_addr_o  out  Cfg.PLEN  request address
- dc_req_wdata_o  out  Cfg.XLEN  write data (0 for reads)
- dc_req_op_o  out  decode_pkg::lsu_op_e  request op
- dc_resp_valid_i  in  1  one response per accepted request, in order
- dc_resp_rdata_i  in  Cfg.XLEN  read data (ignored for writes)
- flush_i  in  1  pipeline flush
- idle_o  out  1  no outstanding requests

Behaviour:
- Reset (asynchronous, active-low):
  - FIFO pointers, count and starve_cnt cleared; all entries invalid.
  - idle_o=1.
  - With requester inputs low, every request/response output is 0.
- full = (count == MAX_OUTSTANDING), using the registered count. A pop in the same cycle does not unblock a push.
- Candidates:
  - ld_cand = ld_req_valid_i && !flush_i. Loads are never issued during a flush.
  - sb_cand = sb_req_valid_i. Committed stores survive a flush.
- Winner selection:
  - urgent = sb_pressure_i || (starve_cnt == STARVE_LIMIT).
  - Store wins if sb_cand && (urgent || !ld_cand).
  - Otherwise load wins if ld_cand.
- Request outputs:
  - dc_req_valid_o = (ld_cand || sb_cand) && !full. It never depends on dc_req_ready_i.
  - Request fields are muxed from the winner.
- Ready outputs:
  - The winner's ready_o = dc_req_ready_i && !full.
  - The loser's ready_o = 0.
- Fire = dc_req_valid_o && dc_req_ready_i.
  - A fire pushes {is_load, killed=0} at the FIFO tail.
- Starvation counter (width $clog2(STARVE_LIMIT+1)):
  - Cleared if !sb_req_valid_i or the store fires.
  - Otherwise increments, saturating at STARVE_LIMIT.
- Response routing (dc_resp_valid_i):
  - Pops the FIFO head.
  - ld_resp_valid_o = dc_resp_valid_i && head.is_load && !head.killed && !flush_i, combinational, same cycle.
  - ld_resp_data_o = dc_resp_rdata_i when ld_resp_valid_o, else 0.
  - Store responses are consumed silently.
- Flush:
  - At the next edge, sets killed on every valid FIFO entry with is_load=1.
  - A response arriving during the flush cycle is dropped and popped normally.
  - Count is not changed by flush: killed entries still await their responses.
- Push and pop in the same cycle:
  - count unchanged.
  - Pointers wrap modulo MAX_OUTSTANDING.
- dc_resp_valid_i with count==0 is a protocol error:
  - Ignored; no pop, no ld_resp.
  - Assertion fires in simulation.
- idle_o = (count == 0).
- Reset mid-operation: all in-flight tags are discarded; responses after reset with count==0 fall under the protocol-error rule.

Test Plan:
1. Load only, dc_req_ready_i=1, addr 0x8000_0010, LSU_LW; 2 cycles later resp rdata 0xDEADBEEF -> dc_req_we_o=0, ld_req_ready_o=1 on the issue cycle; ld_resp_valid_o=1 with data 0xDEADBEEF in the response cycle; idle_o returns to 1.
2. Load and store both valid continuously, sb_pressure_i=0, STARVE_LIMIT=8 -> loads win for 8 cycles, store forced on cycle 9 (sb_req_ready_o=1, dc_req_we_o=1), starve_cnt back to 0.
3. Both valid, sb_pressure_i=1 -> store wins immediately; ld_req_ready_o=0 that cycle.
4. Issue 4 loads with no responses -> after the 4th, dc_req_valid_o=0 and both readys=0 (full). The response in the next cycle does not allow a same-cycle push; issue resumes the cycle after.
5. Two loads and one store in flight, assert flush_i for 1 cycle with ld_req_valid_i=1 -> no load issued during flush; the store may issue. All 3 responses later pop; ld_resp_valid_o stays 0 for both killed loads; idle_o=1 afterwards.
6. Assert rst_ni low while 3 requests are outstanding -> count=0, idle_o=1 immediately. A stray dc_resp_valid_i after release produces no ld_resp_valid_o.
